lsu_ctrl: RTL

- Parametrised load/store unit between the decode/execute stage and the data cache.
- Accepts one memory operation at a time over a valid/ready request channel.
- Generates word-aligned cache accesses with byte enables, shifts store data into the correct lanes, and extracts and sign/zero-extends load data.
- Returns a single-cycle response pulse. Successor to the single-width unit: adds access size, sign extension, byte-lane steering and a real handshake FSM.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_ctrl_if.sv | 55 +++++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM state type and byte-enable helper for the load/store unit
// Contents: SZ_* access-size codes, lsu_state_t (IDLE/ACCESS/RESP), be_calc().
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Byte enables for an access of 2**size bytes starting at byte lane ofs.
    // Sized for the widest (64-bit) path; callers keep the low BE_WIDTH bits.
    function automatic logic [7:0] be_calc(input logic [2:0] ofs, input logic [1:0] size);
        logic [8:0] ones;
        ones = (9'd1 << (4'd1 << size)) - 9'd1;
        return ones[7:0] << ofs;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request/response and data-cache channel interfaces for the load/store unit
// lsu_req_if: req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata in,
//             resp_valid/resp_rdata/resp_err out (slave = LSU side, master = execute stage).
// lsu_mem_if: data_req/data_addr/data_we/data_be/data_wdata out, data_valid/data_rdata in
//             (master = LSU side, slave = data cache).
interface lsu_req_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  data_req;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic                  data_we;
    logic [BE_WIDTH-1:0]   data_be;
    logic [DATA_WIDTH-1:0] data_wdata;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] data_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_valid, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_valid, data_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store-lane shifter and load extract/extend for the load/store unit
// Ports: st_ofs/st_size/st_wdata -> st_lanes (store data placed in its byte lanes, other lanes 0);
//        ld_ofs/ld_size/ld_unsigned/ld_rdata -> ld_result (load data right-aligned and extended).
module lsu_align #(
    parameter int DATA_WIDTH = 32,
    parameter int OFS_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
    input  logic [OFS_WIDTH-1:0]  st_ofs,
    input  logic [1:0]            st_size,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [DATA_WIDTH-1:0] st_lanes,
    input  logic [OFS_WIDTH-1:0]  ld_ofs,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_result
);
    import lsu_pkg::*;

    int                    st_bits;
    int                    ld_bits;
    logic [DATA_WIDTH-1:0] st_masked;
    logic [DATA_WIDTH-1:0] ld_shifted;
    logic                  ld_fill;

    // Store data arrives right-aligned; bits above the access size are cleared
    // so unused lanes go out as 0 rather than stale upper bits.
    always_comb begin
        st_bits   = 8 << st_size;
        st_masked = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            st_masked[i] = (i < st_bits) ? st_wdata[i] : 1'b0;
        end
        st_lanes = st_masked << {st_ofs, 3'b000};
    end

    // A full-width access (word on 32-bit, double on 64-bit) has ld_bits equal to
    // DATA_WIDTH, so every bit comes straight from the shifted read data.
    always_comb begin
        ld_bits    = 8 << ld_size;
        ld_shifted = ld_rdata >> {ld_ofs, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_fill = ~ld_unsigned & ld_shifted[7];
            SZ_HALF: ld_fill = ~ld_unsigned & ld_shifted[15];
            SZ_WORD: ld_fill = ~ld_unsigned & ld_shifted[31];
            default: ld_fill = ~ld_unsigned & ld_shifted[DATA_WIDTH-1];
        endcase
        ld_result = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ld_result[i] = (i < ld_bits) ? ld_shifted[i] : ld_fill;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit FSM between the execute stage and the data cache
// Ports: clk; rst (asynchronous, active-low); req (lsu_req_if.slave, request/response channel);
//        mem (lsu_mem_if.master, data cache channel).
// Build option: LSU_MISALIGN_EN - when defined, misaligned requests fault without a cache
//               access; when undefined, the low address bits are forced to alignment.
module lsu_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    import lsu_pkg::*;

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int OFS_WIDTH = $clog2(BE_WIDTH);

    lsu_state_t state;
    lsu_state_t state_nxt;
    logic       ready_int;
    logic       accept;
    logic       done;

    logic [OFS_WIDTH-1:0]  ofs_raw;
    logic [OFS_WIDTH-1:0]  lo_mask;
    logic [OFS_WIDTH-1:0]  ofs_eff;
    logic                  illegal_size;
    logic                  fault;
    logic [DATA_WIDTH-1:0] st_lanes;
    logic [DATA_WIDTH-1:0] ld_result;

    // Operation fields kept for load extraction when the cache answers.
    logic [1:0]            op_size;
    logic                  op_unsigned;
    logic [OFS_WIDTH-1:0]  op_ofs;

    logic                  data_req_q;
    logic                  data_we_q;
    logic [ADDR_WIDTH-1:0] data_addr_q;
    logic [BE_WIDTH-1:0]   data_be_q;
    logic [DATA_WIDTH-1:0] data_wdata_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    // lo_mask covers the address bits that must be zero for a naturally aligned access.
    assign lo_mask      = OFS_WIDTH'((4'd1 << req.req_size) - 4'd1);
    assign ofs_raw      = req.req_addr[OFS_WIDTH-1:0];
    assign ofs_eff      = ofs_raw & ~lo_mask;
    assign illegal_size = (req.req_size == SZ_DOUBLE) && (DATA_WIDTH == 32);

`ifdef LSU_MISALIGN_EN
    assign fault = illegal_size | (|(ofs_raw & lo_mask));
`else
    assign fault = illegal_size;
`endif

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFS_WIDTH  (OFS_WIDTH)
    ) u_align (
        .st_ofs      (ofs_eff),
        .st_size     (req.req_size),
        .st_wdata    (req.req_wdata),
        .st_lanes    (st_lanes),
        .ld_ofs      (op_ofs),
        .ld_size     (op_size),
        .ld_unsigned (op_unsigned),
        .ld_rdata    (mem.data_rdata),
        .ld_result   (ld_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req.req_valid) state_nxt = fault ? RESP : ACCESS;
            ACCESS:  if (mem.data_valid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // data_valid is only meaningful in ACCESS; elsewhere it is ignored.
    always_comb begin
        ready_int = (state == IDLE);
        accept    = ready_int & req.req_valid;
        done      = (state == ACCESS) & mem.data_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_size      <= SZ_BYTE;
            op_unsigned  <= 1'b0;
            op_ofs       <= '0;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_addr_q  <= '0;
            data_be_q    <= '0;
            data_wdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (accept) begin
                op_size      <= req.req_size;
                op_unsigned  <= req.req_unsigned;
                op_ofs       <= ofs_eff;
                resp_rdata_q <= '0;
                if (fault) begin
                    // Faulting requests skip the cache and respond next cycle.
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                end else begin
                    resp_err_q   <= 1'b0;
                    data_req_q   <= 1'b1;
                    data_we_q    <= req.req_we;
                    data_addr_q  <= {req.req_addr[ADDR_WIDTH-1:OFS_WIDTH], {OFS_WIDTH{1'b0}}};
                    data_be_q    <= BE_WIDTH'(be_calc(3'(ofs_eff), req.req_size));
                    data_wdata_q <= st_lanes;
                end
            end
            if (done) begin
                data_req_q   <= 1'b0;
                data_we_q    <= 1'b0;
                resp_valid_q <= 1'b1;
                resp_err_q   <= 1'b0;
                resp_rdata_q <= data_we_q ? '0 : ld_result;
            end
        end
    end

    assign req.req_ready  = ready_int;
    assign req.resp_valid = resp_valid_q;
    assign req.resp_err   = resp_err_q;
    assign req.resp_rdata = resp_rdata_q;
    assign mem.data_req   = data_req_q;
    assign mem.data_we    = data_we_q;
    assign mem.data_addr  = data_addr_q;
    assign mem.data_be    = data_be_q;
    assign mem.data_wdata = data_wdata_q;

endmodule
